tx_packet_scheduler: RTL and testbench

Sequences the optical transmitter across a block of frame memory. On `start` it walks an inclusive address range, fetches each 36-bit word, launches one packet per word into the serializer, waits for that packet (payload plus CRC tail) to fully drain, inserts a programmable inter-packet gap, and moves on. It sits between the frame buffer and the transmitter. It owns every `transmit_en` pulse in the design.

---
 rtl/tx_sched_pkg.sv | 27 ++
 rtl/tx_sched_timer.sv | 33 +++
 rtl/tx_packet_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_tx_packet_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg
// Shared types and widths for the transmit packet scheduler.
//   sched_state_t : scheduler FSM states
//   ADDR_W/DATA_W : frame-memory address and word widths
//   CNT_W         : launched-packet counter width
//   sat_inc       : saturating increment for the packet counter
package tx_sched_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 36;
    localparam int CNT_W  = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_LAUNCH,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } sched_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tx_sched_timer.sv
// tx_sched_timer
// Loadable 8-bit down-counter. One instance is time-shared by the scheduler
// for the memory-latency wait, the acknowledge watchdog and the gap count.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one, holding at zero
//   o_zero       : count is zero
module tx_sched_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler
// Walks an inclusive frame-memory address range, fetching one 36-bit word per
// address and launching it as one packet into the optical transmitter. After
// each launch it waits for the transmitter to raise and then drop tx_busy,
// inserts gap_cycles idle cycles, then moves to the next address.
//
// Build option: TX_SCHED_LOOP_EN - when defined, the end of the range wraps
// back to first_addr and only stop ends the run; otherwise one pass is made.
//
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   start, stop             : start pulse (IDLE only), stop level (packet boundary)
//   first_addr, last_addr   : inclusive range, sampled on start
//   gap_cycles              : inter-packet gap, sampled on start
//   mem_rd, mem_addr        : frame-memory read request
//   mem_data                : read data, valid MEM_LAT cycles after mem_rd
//   tx_busy                 : transmitter busy (payload + CRC tail)
//   transmit_en             : one-cycle launch pulse
//   to_transmitter_data     : launched payload
//   transmit_address        : address of the launched word
//   active, done, tx_err    : status
//   pkt_count               : packets launched since the last accepted start
//
// state       | meaning
// S_IDLE      | waiting for start
// S_FETCH     | mem_rd asserted for the current address
// S_WAIT_DATA | waiting MEM_LAT cycles for read data
// S_LAUNCH    | transmit_en asserted
// S_WAIT_HI   | waiting for tx_busy to rise (watchdog running)
// S_WAIT_LO   | packet draining, waiting for tx_busy to fall
// S_GAP       | inter-packet gap countdown
module tx_packet_scheduler
    import tx_sched_pkg::*;
#(
    parameter int MEM_LAT     = 1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [7:0]        gap_cycles,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              tx_busy,
    output logic              transmit_en,
    output logic [DATA_W-1:0] to_transmitter_data,
    output logic [ADDR_W-1:0] transmit_address,
    output logic              active,
    output logic              done,
    output logic              tx_err,
    output logic [CNT_W-1:0]  pkt_count
);

    // Timer reload values: the timer is checked on the cycle it reads zero, so
    // loading N-1 yields an N-cycle window.
    localparam logic [7:0] LAT_LOAD = 8'(MEM_LAT - 1);
    localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT - 1);

    sched_state_t      r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last;
`ifdef TX_SCHED_LOOP_EN
    logic [ADDR_W-1:0] r_first;
`endif
    logic [7:0]        r_gap;

    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_transmit_en;
    logic [DATA_W-1:0] r_tx_data;
    logic [ADDR_W-1:0] r_tx_addr;
    logic              r_active;
    logic              r_done;
    logic              r_tx_err;
    logic [CNT_W-1:0]  r_pkt_count;

    logic              w_tmr_load;
    logic [7:0]        w_tmr_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;
    logic              w_decide;
    logic              w_at_end;

    tx_sched_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = 8'd0;
        w_tmr_dec  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = LAT_LOAD;
            end
            S_WAIT_DATA: begin
                if (w_tmr_zero) begin
                    // Arm the watchdog so it covers the LAUNCH cycle too.
                    w_tmr_load = 1'b1;
                    w_tmr_val  = ACK_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            S_LAUNCH, S_WAIT_HI, S_GAP: begin
                w_tmr_dec = 1'b1;
            end
            S_WAIT_LO: begin
                if (!tx_busy && (r_gap != 8'd0)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = r_gap - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Next-packet decision point: end of the gap, or busy falling with no gap.
    assign w_decide = ((r_state == S_WAIT_LO) && !tx_busy && (r_gap == 8'd0)) ||
                      ((r_state == S_GAP) && w_tmr_zero);
    assign w_at_end = (r_cur == r_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_last        <= '0;
`ifdef TX_SCHED_LOOP_EN
            r_first       <= '0;
`endif
            r_gap         <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_transmit_en <= 1'b0;
            r_tx_data     <= '0;
            r_tx_addr     <= '0;
            r_active      <= 1'b0;
            r_done        <= 1'b0;
            r_tx_err      <= 1'b0;
            r_pkt_count   <= '0;
        end else begin
            r_transmit_en <= 1'b0;
            r_done        <= 1'b0;
            r_tx_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (last_addr >= first_addr) begin
`ifdef TX_SCHED_LOOP_EN
                            r_first     <= first_addr;
`endif
                            r_last      <= last_addr;
                            r_gap       <= gap_cycles;
                            r_cur       <= first_addr;
                            r_pkt_count <= '0;
                            r_active    <= 1'b1;
                            r_mem_rd    <= 1'b1;
                            r_mem_addr  <= first_addr;
                            r_state     <= S_FETCH;
                        end else begin
                            r_tx_err <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    if (w_tmr_zero) begin
                        r_tx_data     <= mem_data;
                        r_tx_addr     <= r_cur;
                        r_transmit_en <= 1'b1;
                        r_pkt_count   <= sat_inc(r_pkt_count);
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (w_tmr_zero) begin
                        r_tx_err <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy && (r_gap != 8'd0)) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: ;
                default: r_state <= S_IDLE;
            endcase

            if (w_decide) begin
                if (stop) begin
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end else if (w_at_end) begin
`ifdef TX_SCHED_LOOP_EN
                    r_cur      <= r_first;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_first;
                    r_state    <= S_FETCH;
`else
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
`endif
                end else begin
                    r_cur      <= r_cur + 1'b1;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_cur + 1'b1;
                    r_state    <= S_FETCH;
                end
            end
        end
    end

    assign mem_rd              = r_mem_rd;
    assign mem_addr            = r_mem_addr;
    assign transmit_en         = r_transmit_en;
    assign to_transmitter_data = r_tx_data;
    assign transmit_address    = r_tx_addr;
    assign active              = r_active;
    assign done                = r_done;
    assign tx_err              = r_tx_err;
    assign pkt_count           = r_pkt_count;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// tb_tx_packet_scheduler
// Directed and randomized passes of tx_packet_scheduler against a frame-memory
// model, a transmitter model and an address-sequence reference model.
module tb_tx_packet_scheduler;

    localparam int MEM_LAT     = 1;
    localparam int ACK_TIMEOUT = 4;
`ifdef TX_SCHED_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [18:0] first_addr;
    logic [18:0] last_addr;
    logic [7:0]  gap_cycles;
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic [35:0] mem_data;
    logic        tx_busy;
    logic        transmit_en;
    logic [35:0] to_transmitter_data;
    logic [18:0] transmit_address;
    logic        active;
    logic        done;
    logic        tx_err;
    logic [19:0] pkt_count;

    tx_packet_scheduler #(
        .MEM_LAT     (MEM_LAT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .stop                (stop),
        .first_addr          (first_addr),
        .last_addr           (last_addr),
        .gap_cycles          (gap_cycles),
        .mem_rd              (mem_rd),
        .mem_addr            (mem_addr),
        .mem_data            (mem_data),
        .tx_busy             (tx_busy),
        .transmit_en         (transmit_en),
        .to_transmitter_data (to_transmitter_data),
        .transmit_address    (transmit_address),
        .active              (active),
        .done                (done),
        .tx_err              (tx_err),
        .pkt_count           (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_fail;
    int cyc;
    int start_cyc;

    logic [18:0] q_rd_addr[$];
    int          q_rd_cyc[$];
    logic [18:0] q_tx_addr[$];
    logic [35:0] q_tx_data[$];
    int          q_en_cyc[$];
    int          q_fall_cyc[$];
    int          n_done;
    int          done_cyc;
    logic        done_active;
    int          n_err;
    int          err_cyc;
    logic        err_active;
    bit          saw_active;

    logic [16:0] seed;
    int          busy_len;
    int          busy_delay;
    bit          never_ack;
    int          tx_state;
    int          tx_cnt;

    function automatic logic [35:0] word_of(input logic [18:0] a);
        return {seed ^ a[16:0], a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        q_rd_addr.delete();
        q_rd_cyc.delete();
        q_tx_addr.delete();
        q_tx_data.delete();
        q_en_cyc.delete();
        q_fall_cyc.delete();
        n_done      = 0;
        done_cyc    = -1;
        done_active = 1'bx;
        n_err       = 0;
        err_cyc     = -1;
        err_active  = 1'bx;
        saw_active  = 1'b0;
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Frame memory: data is valid exactly MEM_LAT cycles after mem_rd and is
    // random garbage in every other cycle.
    initial begin
        logic        p0v, p1v, nv;
        logic [18:0] p0a, p1a, na;
        logic [63:0] g;
        p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            p1v = p0v;    p1a = p0a;
            p0v = mem_rd; p0a = mem_addr;
            nv  = (MEM_LAT == 1) ? p0v : p1v;
            na  = (MEM_LAT == 1) ? p0a : p1a;
            @(posedge clk);
            #1;
            g = {$urandom(), $urandom()};
            mem_data = nv ? word_of(na) : g[35:0];
        end
    end

    // Event monitor plus transmitter model (busy after busy_delay cycles,
    // held for busy_len cycles; never raised when never_ack is set).
    initial begin
        tx_state = 0;
        tx_cnt   = 0;
        tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                q_rd_addr.push_back(mem_addr);
                q_rd_cyc.push_back(cyc);
            end
            if (transmit_en) begin
                q_tx_addr.push_back(transmit_address);
                q_tx_data.push_back(to_transmitter_data);
                q_en_cyc.push_back(cyc);
            end
            if (done) begin
                n_done++;
                done_cyc    = cyc;
                done_active = active;
            end
            if (tx_err) begin
                n_err++;
                err_cyc    = cyc;
                err_active = active;
            end
            if (active) saw_active = 1'b1;
            case (tx_state)
                0: if (transmit_en && !never_ack) begin
                    tx_cnt   = busy_delay;
                    tx_state = 1;
                end
                1: if (tx_cnt == 0) begin
                    tx_busy  = 1'b1;
                    tx_cnt   = busy_len - 1;
                    tx_state = 2;
                end else begin
                    tx_cnt--;
                end
                default: if (tx_cnt == 0) begin
                    tx_busy  = 1'b0;
                    q_fall_cyc.push_back(cyc);
                    tx_state = 0;
                end else begin
                    tx_cnt--;
                end
            endcase
        end
    end

    task automatic pulse_start(input logic [18:0] lo, input logic [18:0] hi, input logic [7:0] gap);
        @(negedge clk);
        #1;
        first_addr = lo;
        last_addr  = hi;
        gap_cycles = gap;
        start      = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one pass/run and checks it against the expected address sequence.
    // stop_after > 0 raises stop once that many packets have been launched.
    task automatic run_pass(input string tag, input logic [18:0] lo, input logic [18:0] hi,
                            input logic [7:0] gap, input int stop_after);
        int          n;
        int          exp_cnt;
        logic [18:0] exp_a;
        clear_logs();
        pulse_start(lo, hi, gap);
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            #1;
            if (stop_after > 0 && q_tx_addr.size() >= stop_after) stop = 1'b1;
            if (n_done > 0 || n_err > 0) break;
        end
        repeat (6) @(negedge clk);
        #1;
        stop = 1'b0;

        n = int'(hi) - int'(lo) + 1;
        if (stop_after == 0)      exp_cnt = n;
        else if (LOOP)            exp_cnt = stop_after;
        else                      exp_cnt = (stop_after < n) ? stop_after : n;

        chk({tag, "_done_count"}, 64'(n_done), 64'(1));
        chk({tag, "_err_count"}, 64'(n_err), 64'(0));
        chk({tag, "_launch_count"}, 64'(q_tx_addr.size()), 64'(exp_cnt));
        chk({tag, "_read_count"}, 64'(q_rd_addr.size()), 64'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < q_tx_addr.size(); i++) begin
            exp_a = lo + 19'(i % n);
            chk($sformatf("%s_txaddr%0d", tag, i), 64'(q_tx_addr[i]), 64'(exp_a));
            chk($sformatf("%s_txdata%0d", tag, i), 64'(q_tx_data[i]), 64'(word_of(exp_a)));
        end
        for (int i = 0; i < exp_cnt && i < q_rd_addr.size(); i++) begin
            exp_a = lo + 19'(i % n);
            chk($sformatf("%s_rdaddr%0d", tag, i), 64'(q_rd_addr[i]), 64'(exp_a));
        end
        if (q_en_cyc.size() > 0)
            chk({tag, "_launch_latency"}, 64'(q_en_cyc[0] - start_cyc), 64'(MEM_LAT + 2));
        for (int i = 1; i < q_rd_cyc.size() && i - 1 < q_fall_cyc.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), 64'(q_rd_cyc[i] - q_fall_cyc[i-1]), 64'(int'(gap) + 1));
        if (q_fall_cyc.size() > 0)
            chk({tag, "_done_timing"}, 64'(done_cyc - q_fall_cyc[q_fall_cyc.size()-1]), 64'(int'(gap) + 1));
        chk({tag, "_active_at_done"}, 64'(done_active), 64'(0));
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_cnt));
        chk({tag, "_active_after"}, 64'(active), 64'(0));
    endtask

    initial begin
        int n;
        int lo_i;
        n_vec      = 0;
        n_fail     = 0;
        seed       = 17'($urandom());
        busy_len   = 5;
        busy_delay = 0;
        never_ack  = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        gap_cycles = '0;
        clear_logs();

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({mem_rd, transmit_en, active, done, tx_err}), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        chk("reset_tx_data", 64'(to_transmitter_data), 64'(0));
        chk("reset_tx_addr", 64'(transmit_address), 64'(0));
        chk("reset_pkt_count", 64'(pkt_count), 64'(0));
        #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        busy_len   = 77;
        busy_delay = 0;
        run_pass("basic", 19'h10, 19'h12, 8'd3, LOOP ? 3 : 0);

        clear_logs();
        pulse_start(19'd5, 19'd4, 8'd2);
        repeat (5) @(negedge clk);
        chk("reject_err_count", 64'(n_err), 64'(1));
        chk("reject_err_timing", 64'(err_cyc - start_cyc), 64'(1));
        chk("reject_active", 64'(saw_active), 64'(0));
        chk("reject_no_read", 64'(q_rd_addr.size()), 64'(0));
        chk("reject_no_done", 64'(n_done), 64'(0));

        never_ack = 1'b1;
        clear_logs();
        pulse_start(19'h20, 19'h22, 8'd1);
        for (int k = 0; k < 200 && n_err == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("timeout_err_count", 64'(n_err), 64'(1));
        chk("timeout_launch_count", 64'(q_en_cyc.size()), 64'(1));
        if (q_en_cyc.size() > 0)
            chk("timeout_err_timing", 64'(err_cyc - q_en_cyc[0]), 64'(ACK_TIMEOUT));
        chk("timeout_active_at_err", 64'(err_active), 64'(0));
        chk("timeout_pkt_count", 64'(pkt_count), 64'(1));
        chk("timeout_no_done", 64'(n_done), 64'(0));
        chk("timeout_active_after", 64'(active), 64'(0));
        never_ack = 1'b0;

        busy_len   = 9;
        busy_delay = 1;
        run_pass("stop", 19'h40, 19'h44, 8'd2, 2);

        busy_len   = 3;
        busy_delay = 2;
        run_pass("top", 19'h7FFFE, 19'h7FFFF, 8'd1, LOOP ? 4 : 0);

        busy_len   = 30;
        busy_delay = 0;
        clear_logs();
        pulse_start(19'h100, 19'h102, 8'd2);
        for (int k = 0; k < 200 && !(q_en_cyc.size() > 0 && tx_busy); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({mem_rd, transmit_en, active, done, tx_err}), 64'(0));
        chk("midrst_mem_addr", 64'(mem_addr), 64'(0));
        chk("midrst_tx_data", 64'(to_transmitter_data), 64'(0));
        chk("midrst_tx_addr", 64'(transmit_address), 64'(0));
        chk("midrst_pkt_count", 64'(pkt_count), 64'(0));
        for (int k = 0; k < 200 && tx_busy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        busy_len = 6;
        run_pass("cold", 19'h200, 19'h202, 8'd0, LOOP ? 3 : 0);

        for (int r = 0; r < 4; r++) begin
            n          = int'($urandom_range(1, 4));
            lo_i       = int'($urandom_range(0, 19'h7FFFF - 4));
            busy_len   = int'($urandom_range(1, 12));
            busy_delay = int'($urandom_range(0, ACK_TIMEOUT - 2));
            run_pass($sformatf("rand%0d", r), 19'(lo_i), 19'(lo_i + n - 1),
                     8'($urandom_range(0, 5)), LOOP ? n + 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
